// File: rtl/bits2bytes_stream.sv
// Streaming bit-group to byte packer: IN_BITS-wide groups are accumulated LSB-first
// and emitted as bytes, with the final partial byte of each frame zero-padded.
module bits2bytes_stream #(
  parameter int IN_BITS = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [IN_BITS-1:0] bits_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               in_last_i,
  output logic [7:0]         byte_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_last_o
);

  localparam int ACC_W = IN_BITS + 15;
  localparam int CNT_W = $clog2(ACC_W + 1);

  if (IN_BITS < 1 || IN_BITS > 16) begin : g_bad_in_bits
    $error("bits2bytes_stream: IN_BITS must lie in 1..16");
  end

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_in_fire;
  logic              w_out_fire;
  logic [ACC_W-1:0]  w_acc_pop;
  logic [CNT_W-1:0]  w_cnt_pop;
  logic [ACC_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]  w_cnt_next;

  // Valid/ready on both sides: a transfer happens on a rising edge where valid and
  // ready are both high; all outputs decode registered state only, so neither
  // in_valid_i nor out_ready_i reaches any output combinationally.
  assign byte_o      = r_acc[7:0];
  assign in_ready_o  = (r_state == ST_RUN) && (r_cnt <= CNT_W'(15));
  assign out_valid_o = ((r_state == ST_RUN)   && (r_cnt >= CNT_W'(8))) ||
                       ((r_state == ST_FLUSH) && (r_cnt >= CNT_W'(1)));
  assign out_last_o  = (r_state == ST_FLUSH) && (r_cnt <= CNT_W'(8));

  assign w_in_fire  = in_valid_i && in_ready_o;
  assign w_out_fire = out_valid_o && out_ready_i;

  // Pop first, then append the new group at the post-pop bit count.
  always_comb begin
    w_acc_pop  = r_acc;
    w_cnt_pop  = r_cnt;
    if (w_out_fire) begin
      w_acc_pop = r_acc >> 8;
      w_cnt_pop = (r_cnt >= CNT_W'(8)) ? (r_cnt - CNT_W'(8)) : '0;
    end
    w_acc_next = w_acc_pop;
    w_cnt_next = w_cnt_pop;
    if (w_in_fire) begin
      w_acc_next = w_acc_pop | (ACC_W'(bits_i) << w_cnt_pop);
      w_cnt_next = w_cnt_pop + CNT_W'(IN_BITS);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      case (r_state)
        ST_RUN: begin
          if (w_in_fire && in_last_i) r_state <= ST_FLUSH;
        end
        ST_FLUSH: begin
          if (w_out_fire && out_last_o) begin
            r_state <= ST_RUN;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bits2bytes_stream.sv
// Bench for bits2bytes_stream: directed cycle-level steps on 12/8/4-bit instances,
// then randomized frames on the 12-bit instance scored against a bit-queue model.
module tb_bits2bytes_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 12-bit instance
  logic [11:0] a_bits;
  logic        a_in_valid, a_in_last, a_out_ready;
  logic        a_in_ready, a_out_valid, a_out_last;
  logic [7:0]  a_byte;
  // 8-bit instance
  logic [7:0]  b_bits;
  logic        b_in_valid, b_in_last, b_out_ready;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [7:0]  b_byte;
  // 4-bit instance
  logic [3:0]  c_bits;
  logic        c_in_valid, c_in_last, c_out_ready;
  logic        c_in_ready, c_out_valid, c_out_last;
  logic [7:0]  c_byte;

  logic [8:0] exp_q[$];

  bits2bytes_stream #(.IN_BITS(12)) u_dut12 (
    .clk_i(clk), .rst_i(rst), .bits_i(a_bits), .in_valid_i(a_in_valid),
    .in_ready_o(a_in_ready), .in_last_i(a_in_last), .byte_o(a_byte),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_last_o(a_out_last)
  );
  bits2bytes_stream #(.IN_BITS(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .bits_i(b_bits), .in_valid_i(b_in_valid),
    .in_ready_o(b_in_ready), .in_last_i(b_in_last), .byte_o(b_byte),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_last_o(b_out_last)
  );
  bits2bytes_stream #(.IN_BITS(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .bits_i(c_bits), .in_valid_i(c_in_valid),
    .in_ready_o(c_in_ready), .in_last_i(c_in_last), .byte_o(c_byte),
    .out_valid_o(c_out_valid), .out_ready_i(c_out_ready), .out_last_o(c_out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: concatenate each frame's bits in stream order, pad to a byte
  // boundary at the last beat, and slice into bytes tagged with the last flag.
  function automatic void model_push(input logic [15:0] beats[$], input bit lasts[$],
                                     input int w);
    bit         bq[$];
    logic [7:0] by;
    foreach (beats[i]) begin
      for (int b = 0; b < w; b++) bq.push_back(beats[i][b]);
      if (lasts[i]) begin
        while (bq.size() % 8 != 0) bq.push_back(1'b0);
        while (bq.size() > 0) begin
          for (int b = 0; b < 8; b++) by[b] = bq.pop_front();
          exp_q.push_back({bq.size() == 0, by});
        end
      end
    end
  endfunction

  task automatic run_random12(input int n_frames, input int valid_pct, input int ready_pct);
    logic [15:0] beats[$];
    bit          lasts[$];
    int          nb, bi, cyc;
    bit          held, prev_stall;
    logic [7:0]  prev_byte;
    logic        prev_last;
    logic [8:0]  e;
    for (int f = 0; f < n_frames; f++) begin
      nb = $urandom_range(1, 5);
      for (int j = 0; j < nb; j++) begin
        beats.push_back(16'($urandom_range(0, 4095)));
        lasts.push_back(j == nb - 1);
      end
    end
    model_push(beats, lasts, 12);
    bi = 0; cyc = 0; held = 0; prev_stall = 0; prev_byte = '0; prev_last = 0;
    while ((bi < beats.size() || exp_q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        check("hold_byte", a_byte, prev_byte);
        check("hold_last", a_out_last, prev_last);
      end
      if (!held) begin
        if (bi < beats.size() && $urandom_range(0, 99) < valid_pct) begin
          a_in_valid = 1; a_bits = beats[bi][11:0]; a_in_last = lasts[bi];
        end else begin
          a_in_valid = 0; a_bits = 12'($urandom); a_in_last = 1'($urandom);
        end
      end
      a_out_ready = ($urandom_range(0, 99) < ready_pct);
      if (a_in_valid && a_in_ready) begin
        bi++; held = 0;
      end else begin
        held = a_in_valid;
      end
      if (a_out_valid && a_out_ready) begin
        check("rnd_expected_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rnd_byte", a_byte, e[7:0]);
          check("rnd_last", a_out_last, e[8]);
        end
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev_byte  = a_byte;
      prev_last  = a_out_last;
    end
    check("rnd_drained", exp_q.size() + (beats.size() - bi), 0);
    exp_q.delete();
    @(negedge clk);
    a_in_valid = 0; a_out_ready = 1;
  endtask

  initial begin
    logic [7:0] exp3[5];
    int         k;
    bit         fired;
    exp3 = '{8'hBC, 8'h3A, 8'h12, 8'h56, 8'h04};

    // clock/reset
    rst = 1;
    a_bits = '0; a_in_valid = 0; a_in_last = 0; a_out_ready = 0;
    b_bits = '0; b_in_valid = 0; b_in_last = 0; b_out_ready = 0;
    c_bits = '0; c_in_valid = 0; c_in_last = 0; c_out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_byte", a_byte, 8'h00);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_last", a_out_last, 1'b0);
    check("rst_in_ready", a_in_ready, 1'b1);

    // two beats, three bytes, last on the padded-free final byte
    a_bits = 12'hABC; a_in_valid = 1; a_in_last = 0; a_out_ready = 1;
    @(negedge clk);
    check("t1_b0", a_byte, 8'hBC);
    check("t1_v0", a_out_valid, 1'b1);
    check("t1_l0", a_out_last, 1'b0);
    a_bits = 12'h123; a_in_last = 1;
    @(negedge clk);
    check("t1_b1", a_byte, 8'h3A);
    check("t1_l1", a_out_last, 1'b0);
    check("t1_flush_rdy", a_in_ready, 1'b0);
    a_in_valid = 0; a_bits = 12'hFFF; a_in_last = 0;
    @(negedge clk);
    check("t1_b2", a_byte, 8'h12);
    check("t1_l2", a_out_last, 1'b1);
    @(negedge clk);
    check("t1_idle_valid", a_out_valid, 1'b0);
    check("t1_idle_rdy", a_in_ready, 1'b1);

    // single beat frame, upper nibble padded
    a_bits = 12'h005; a_in_valid = 1; a_in_last = 1;
    @(negedge clk);
    check("t2_b0", a_byte, 8'h05);
    check("t2_l0", a_out_last, 1'b0);
    a_in_valid = 0; a_bits = 12'hFFF;
    @(negedge clk);
    check("t2_b1", a_byte, 8'h00);
    check("t2_v1", a_out_valid, 1'b1);
    check("t2_l1", a_out_last, 1'b1);
    @(negedge clk);
    check("t2_idle_valid", a_out_valid, 1'b0);
    check("t2_idle_rdy", a_in_ready, 1'b1);

    // backpressure: input stalls at cnt=24, BC held until release
    a_out_ready = 0; a_bits = 12'hABC; a_in_valid = 1; a_in_last = 0;
    @(negedge clk);
    check("t3_rdy12", a_in_ready, 1'b1);
    check("t3_hold0", a_byte, 8'hBC);
    a_bits = 12'h123;
    @(negedge clk);
    a_bits = 12'h456; a_in_last = 1;
    for (int i = 0; i < 4; i++) begin
      check("t3_stall_rdy", a_in_ready, 1'b0);
      check("t3_hold_byte", a_byte, 8'hBC);
      check("t3_hold_valid", a_out_valid, 1'b1);
      @(negedge clk);
    end
    a_out_ready = 1;
    check("t3_rel_b0", a_byte, exp3[0]);
    check("t3_rel_l0", a_out_last, 1'b0);
    k = 1; fired = 0;
    for (int i = 0; i < 15 && k < 5; i++) begin
      @(negedge clk);
      if (fired) begin a_in_valid = 0; a_bits = 12'hFFF; end
      if (a_out_valid) begin
        check("t3_rel_byte", a_byte, exp3[k]);
        check("t3_rel_last", a_out_last, k == 4);
        k++;
      end
      fired = a_in_valid && a_in_ready;
    end
    check("t3_byte_count", k, 5);
    a_in_valid = 0;
    @(negedge clk);
    check("t3_idle_valid", a_out_valid, 1'b0);
    check("t3_idle_rdy", a_in_ready, 1'b1);

    // IN_BITS=8 throughput: one byte per cycle, last with 07
    b_bits = 8'h00; b_in_valid = 1; b_in_last = 0; b_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("t4_valid", b_out_valid, 1'b1);
      check("t4_byte", b_byte, 8'(i - 1));
      check("t4_last", b_out_last, i == 8);
      if (i < 8) begin
        check("t4_rdy", b_in_ready, 1'b1);
        b_bits = 8'(i); b_in_last = (i == 7);
      end else begin
        b_in_valid = 0;
      end
    end
    @(negedge clk);
    check("t4_idle", b_out_valid, 1'b0);

    // IN_BITS=4 back-to-back frames, no leakage
    c_bits = 4'h1; c_in_valid = 1; c_in_last = 0; c_out_ready = 1;
    @(negedge clk);
    check("t5_half_valid", c_out_valid, 1'b0);
    c_bits = 4'h2; c_in_last = 1;
    @(negedge clk);
    check("t5_a_byte", c_byte, 8'h21);
    check("t5_a_last", c_out_last, 1'b1);
    check("t5_flush_rdy", c_in_ready, 1'b0);
    c_bits = 4'hF; c_in_last = 1;
    @(negedge clk);
    check("t5_gap_valid", c_out_valid, 1'b0);
    check("t5_gap_rdy", c_in_ready, 1'b1);
    @(negedge clk);
    c_in_valid = 0;
    check("t5_b_byte", c_byte, 8'h0F);
    check("t5_b_last", c_out_last, 1'b1);
    @(negedge clk);
    check("t5_idle", c_out_valid, 1'b0);

    // reset mid-FLUSH after the first byte is consumed
    a_bits = 12'hABC; a_in_valid = 1; a_in_last = 0; a_out_ready = 1;
    @(negedge clk);
    a_bits = 12'h123; a_in_last = 1;
    @(negedge clk);
    check("t6_pre_byte", a_byte, 8'h3A);
    a_in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("t6_rst_valid", a_out_valid, 1'b0);
    check("t6_rst_rdy", a_in_ready, 1'b1);
    check("t6_rst_byte", a_byte, 8'h00);
    check("t6_rst_last", a_out_last, 1'b0);
    a_bits = 12'h0FF; a_in_valid = 1; a_in_last = 1;
    @(negedge clk);
    a_in_valid = 0;
    check("t6_b0", a_byte, 8'hFF);
    check("t6_l0", a_out_last, 1'b0);
    @(negedge clk);
    check("t6_b1", a_byte, 8'h00);
    check("t6_l1", a_out_last, 1'b1);
    @(negedge clk);
    check("t6_idle", a_out_valid, 1'b0);

    // randomized frames with random valid gaps and backpressure
    run_random12(8, 70, 60);
    run_random12(8, 100, 30);
    run_random12(8, 40, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
